// File: rtl/sink.sv
// sink: traffic consumer at a NoC output port, counterpart of the src generator.
// Accepts flits over valid/ready, decodes {dest, vc, id, seq} from the low bits,
// and checks destination, source ID and per-source strictly increasing sequence.
// Optional feature macro: SINK_BACKPRESSURE_EN (LFSR-driven ready_out, ~75% duty).
// Ports:
//   clk        clock
//   rst        synchronous active-low reset
//   data_in    flit payload
//   valid_in   flit valid
//   ready_out  sink can accept a flit this cycle
//   done       rx_count >= NUM_TESTS
//   rx_count   flits accepted and checked
//   err_count  flits failing any check (saturating)
//   err_flag   sticky error indicator
module sink #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned N             = 16,
  parameter int unsigned NUM_VC        = 2,
  parameter int unsigned N_ADDR_WIDTH  = $clog2(N),
  parameter int unsigned VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter int unsigned NODE          = 1,
  parameter int unsigned NUM_SRC       = 4,
  parameter logic [7:0]  SRC_ID [0:NUM_SRC-1] = '{8'd0, 8'd1, 8'd2, 8'd3},
  parameter int unsigned NUM_TESTS     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             done,
  output logic [31:0]      rx_count,
  output logic [15:0]      err_count,
  output logic             err_flag
);

  localparam int unsigned CNT_W    = WIDTH - 2*N_ADDR_WIDTH - 8;
  localparam int unsigned ID_LSB   = CNT_W;
  localparam int unsigned DEST_LSB = CNT_W + 8 + VC_ADDR_WIDTH;
  localparam int unsigned IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Stage 1: captured flit fields
  logic                    cap_v;
  logic [CNT_W-1:0]        cap_seq;
  logic [7:0]              cap_id;
  logic [N_ADDR_WIDTH-1:0] cap_dest;

  logic [CNT_W-1:0]        last_seq [0:NUM_SRC-1];

  logic                    id_hit;
  logic [IDX_W-1:0]        idx;
  logic                    dest_err;
  logic                    id_err;
  logic                    seq_err;
  logic                    flit_err;
  logic                    ready_nxt;
  logic                    xfer;

  // vc and bits above dest are carried but not checked
  logic unused_data;
  assign unused_data = ^data_in;

  assign xfer = valid_in && ready_out;

`ifdef SINK_BACKPRESSURE_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; ready_out tracks the stepped value
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  assign lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign ready_nxt = (lfsr_nxt[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= lfsr_nxt;
  end
`else
  assign ready_nxt = 1'b1;
`endif

  // Source lookup: scan from the top so the lowest matching index wins
  always_comb begin
    id_hit = 1'b0;
    idx    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cap_id == SRC_ID[i]) begin
        id_hit = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

  assign dest_err = (cap_dest != N_ADDR_WIDTH'(NODE));
  assign id_err   = !id_hit;
  // Wrap-around (all-ones -> 0) naturally fails this compare
  assign seq_err  = id_hit && (cap_seq <= last_seq[idx]);
  assign flit_err = dest_err || id_err || seq_err;

  assign done = (rx_count >= 32'(NUM_TESTS));

  // Capture stage, check stage and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_out <= 1'b0;
      cap_v     <= 1'b0;
      cap_seq   <= '0;
      cap_id    <= '0;
      cap_dest  <= '0;
      rx_count  <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) last_seq[i] <= '0;
    end else begin
      ready_out <= ready_nxt;
      cap_v     <= xfer;
      if (xfer) begin
        cap_seq  <= data_in[CNT_W-1:0];
        cap_id   <= data_in[ID_LSB +: 8];
        cap_dest <= data_in[DEST_LSB +: N_ADDR_WIDTH];
      end
      if (cap_v) begin
        rx_count <= rx_count + 32'd1;
        if (flit_err) begin
          err_flag <= 1'b1;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
        // Tracked even when the flit itself is flagged as a seq error
        if (id_hit) last_seq[idx] <= cap_seq;
      end
    end
  end

endmodule

// File: tb/tb_sink.sv
// Randomized scoreboard bench for sink: stimulus pushes expected counter state per
// accepted flit; a negedge monitor pops it two edges after the transfer.
module tb_sink;

  localparam int WIDTH     = 32;
  localparam int NAW       = 4;
  localparam int VCW       = 1;
  localparam int CNT_W     = WIDTH - 2*NAW - 8;
  localparam int NODE      = 1;
  localparam int NUM_TESTS = 12;
  localparam int SEQ_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_in = 1'b0;
  logic             ready_out;
  logic             done;
  logic [31:0]      rx_count;
  logic [15:0]      err_count;
  logic             err_flag;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int rx;
    int err;
    bit flag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int src_ids [4] = '{0, 1, 2, 3};
  int last_seq[4];
  int m_rx;
  int m_err;
  bit m_flag;

  sink #(
    .WIDTH(WIDTH), .N(16), .NUM_VC(2), .NODE(NODE), .NUM_SRC(4),
    .NUM_TESTS(NUM_TESTS)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .done(done), .rx_count(rx_count),
    .err_count(err_count), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_rx = 0;
    m_err = 0;
    m_flag = 0;
    foreach (last_seq[i]) last_seq[i] = 0;
  endfunction

  // Apply one accepted flit to the model and queue the resulting counter state
  function automatic void model_accept(input int id, input int seq, input int dest);
    bit e = 0;
    int k = -1;
    if (dest != NODE) e = 1;
    foreach (src_ids[i]) if (k < 0 && src_ids[i] == id) k = i;
    if (k < 0) e = 1;
    else begin
      if (seq <= last_seq[k]) e = 1;
      last_seq[k] = seq;
    end
    m_rx++;
    if (e) begin
      m_flag = 1;
      if (m_err < 65535) m_err++;
    end
    exp_q.push_back('{m_rx, m_err, m_flag});
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input int id, input int seq, input int dest);
    logic [WIDTH-1:0] d;
    bit acc = 0;
    d = $urandom();
    d[CNT_W-1:0]          = CNT_W'(seq);
    d[CNT_W +: 8]         = 8'(id);
    d[CNT_W+8+VCW +: NAW] = NAW'(dest);
    data_in  = d;
    valid_in = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      acc = ready_out;
      if (acc) model_accept(id, seq & SEQ_MAX, dest);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: per-cycle compare of counters against the scoreboard
  initial begin : monitor
    bit   p1 = 0;
    bit   p2 = 0;
    exp_t cur;
    cur = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (p2) begin
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
      end
      check("rx_count", rx_count, cur.rx);
      check("err_count", err_count, cur.err);
      check("err_flag", err_flag, cur.flag);
      check("done", done, cur.rx >= NUM_TESTS);
      if (!rst) begin
        // The flit accepted just before a reset edge is dropped
        if (p1 && exp_q.size() > 0) void'(exp_q.pop_front());
        p1 = 0;
        p2 = 0;
        cur = '{0, 0, 0};
      end else begin
        p2 = p1;
        p1 = valid_in && ready_out;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int pick, id, seq, dest;
    model_reset();
    rst = 1'b0;
    valid_in = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", ready_out, 0);
    check("rst_rx", rx_count, 0);
    check("rst_err", err_count, 0);
    check("rst_flag", err_flag, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    @(posedge clk); #1;
`ifndef SINK_BACKPRESSURE_EN
    check("ready_after_rst", ready_out, 1);
`endif

    // T1: clean back-to-back stream from id 0
    send(0, 1, 1); send(0, 2, 1); send(0, 3, 1);
    idle(2);
    check("t1_rx", rx_count, 3);
    check("t1_err", err_count, 0);
    check("t1_flag", err_flag, 0);

    // T2: repeated sequence number
    send(2, 5, 1); send(2, 5, 1);
    idle(2);
    check("t2_err", err_count, 1);
    check("t2_flag", err_flag, 1);
    check("t2_rx", rx_count, 5);

    // T3: wrong dest, unknown id, both at once counts once
    send(0, 4, 3); send(9, 1, 1); send(9, 1, 5);
    idle(2);
    check("t3_err", err_count, 4);
    check("t3_rx", rx_count, 8);

    // Sequence wrap is an error
    send(3, SEQ_MAX, 1); send(3, 0, 1);
    idle(2);
    check("wrap_err", err_count, 5);

    // T5: done boundary at NUM_TESTS
    send(1, 1, 1);
    idle(2);
    check("t5_done_low", done, 0);
    send(1, 2, 1);
    idle(2);
    check("t5_done_high", done, 1);
    check("t5_rx", rx_count, 12);
    send(1, 3, 1);
    idle(2);
    check("t5_done_stays", done, 1);
    check("t5_rx_after", rx_count, 13);

    // T6: reset right after an accepted flit
    send(0, 5, 1);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    check("t6_ready", ready_out, 0);
    check("t6_rx", rx_count, 0);
    check("t6_err", err_count, 0);
    check("t6_flag", err_flag, 0);
    idle(1);
    send(0, 1, 1);
    idle(2);
    check("t6_post_rx", rx_count, 1);
    check("t6_post_err", err_count, 0);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
        pick = $urandom_range(0, 9);
        if (pick < 8) id = pick % 4;
        else id = (pick == 8) ? 9 : 8'h41;
        if (id < 4 && $urandom_range(0, 5) != 0)
          seq = (last_seq[id] + $urandom_range(1, 3)) & SEQ_MAX;
        else
          seq = $urandom_range(0, 8);
        dest = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : NODE;
        send(id, seq, dest);
      end
    end

    idle(3);
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
